accum_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one accum instance between NUM_REQ packet requesters. It grants one requester at a time and clears the accumulator. It then streams that requester's samples into the accumulator until the last beat. Finally it returns the sum, tagged with the requester id, on a valid/ready result port. It sits between the requester streams and the accum datapath (clk, rst, en, data_in, data_out).

---
 rtl/accum_arbiter_if.sv | 46 ++++
 rtl/accum_arbiter.sv | 139 +++++++++++++
 tb/tb_accum_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_arbiter_if.sv
// Requester streams and tagged result port shared by accum_arbiter and its environment.
// master drives requests and consumes results; slave is the arbiter side.
interface accum_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ),
    parameter int unsigned CNT_WIDTH = 8
) ();

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ*IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;

    logic                        res_valid;
    logic                        res_ready;
    logic [OUT_WIDTH-1:0]        res_data;
    logic [ID_WIDTH-1:0]         res_id;
    logic [CNT_WIDTH-1:0]        res_count;

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output res_ready,
        input  req_ready,
        input  res_valid,
        input  res_data,
        input  res_id,
        input  res_count
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  res_ready,
        output req_ready,
        output res_valid,
        output res_data,
        output res_id,
        output res_count
    );

endinterface

// File: rtl/accum_arbiter.sv
// Round-robin sequencer sharing one registered accumulator between NUM_REQ packet requesters:
// grant, clear, stream beats, then return the tagged sum on a valid/ready result port.
module accum_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ),
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    accum_arbiter_if.slave       bus,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic [IN_WIDTH-1:0]  acc_data_in,
    input  logic [OUT_WIDTH-1:0] acc_data_out
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StResult
    } state_e;

    state_e               state_q;
    logic [ID_WIDTH-1:0]  gnt_q;
    logic [ID_WIDTH-1:0]  ptr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 clr_q;
    logic                 res_valid_q;
    logic [OUT_WIDTH-1:0] res_data_q;
    logic [ID_WIDTH-1:0]  res_id_q;
    logic [CNT_WIDTH-1:0] res_count_q;

    logic                 any_valid;
    logic [ID_WIDTH-1:0]  winner;
    logic [IN_WIDTH-1:0]  slice [NUM_REQ];
    logic                 gnt_valid;
    logic                 gnt_last;
    logic                 beat;
    logic [NUM_REQ-1:0]   gnt_onehot;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = bus.req_data[g*IN_WIDTH +: IN_WIDTH];
    end

    // Search upward from ptr+1 with wrap; the last requester visited is ptr itself.
    always_comb begin
        int unsigned idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!any_valid && bus.req_valid[ID_WIDTH'(idx)]) begin
                any_valid = 1'b1;
                winner    = ID_WIDTH'(idx);
            end
        end
    end

    assign gnt_valid  = bus.req_valid[gnt_q];
    assign gnt_last   = bus.req_last[gnt_q];
    assign beat       = (state_q == StStream) && gnt_valid;
    assign gnt_onehot = NUM_REQ'(1) << gnt_q;

    assign acc_en      = beat;
    // The data mux follows gnt in every state but is forced quiet while reset is held.
    assign acc_data_in = rst ? slice[gnt_q] : '0;
    assign acc_clr     = clr_q;

    assign bus.req_ready = ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_count = res_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            ptr_q       <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q       <= '0;
            ready_q     <= '0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        gnt_q   <= winner;
                        ptr_q   <= winner;
                        clr_q   <= 1'b1;
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    clr_q   <= 1'b0;
                    cnt_q   <= '0;
                    ready_q <= gnt_onehot;
                    state_q <= StStream;
                end
                StStream: begin
                    if (beat) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (gnt_last) begin
                            ready_q <= '0;
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The last beat landed in the accumulator on the previous edge.
                    res_data_q  <= acc_data_out;
                    res_id_q    <= gnt_q;
                    res_count_q <= cnt_q;
                    res_valid_q <= 1'b1;
                    state_q     <= StResult;
                end
                StResult: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_arbiter.sv
// Directed bench for accum_arbiter with a behavioural registered accumulator attached.
module tb_accum_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned IN_WIDTH  = 8;
    localparam int unsigned OUT_WIDTH = 16;
    localparam int unsigned ID_WIDTH  = 2;
    localparam int unsigned CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 acc_clr;
    logic                 acc_en;
    logic [IN_WIDTH-1:0]  acc_data_in;
    logic [OUT_WIDTH-1:0] acc_q = '0;

    accum_arbiter_if #(
        .NUM_REQ  (NUM_REQ),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .ID_WIDTH (ID_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    accum_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .ID_WIDTH (ID_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .acc_data_in (acc_data_in),
        .acc_data_out(acc_q)
    );

    always #5 clk = ~clk;

    // Registered accumulator with synchronous clear; not touched by rst.
    always @(posedge clk) begin
        if (acc_clr) acc_q <= '0;
        else if (acc_en) acc_q <= acc_q + OUT_WIDTH'(acc_data_in);
    end

    int clr_seen = 0;
    int en_seen  = 0;
    int rv_seen  = 0;

    always @(negedge clk) begin
        if (rst && acc_clr) clr_seen++;
        if (rst && acc_en) en_seen++;
        if (rst && bus.res_valid) rv_seen++;
    end

    typedef struct {
        int id;
        int len;
        int base;
        int step;
        int exp_sum;
        int exp_cnt;
    } vec_t;

    vec_t vecs [5];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, int'(bus.req_ready), 0);
        check({tag, "_acc_clr"}, int'(acc_clr), 0);
        check({tag, "_acc_en"}, int'(acc_en), 0);
        check({tag, "_acc_data_in"}, int'(acc_data_in), 0);
        check({tag, "_res_valid"}, int'(bus.res_valid), 0);
        check({tag, "_res_data"}, int'(bus.res_data), 0);
        check({tag, "_res_id"}, int'(bus.res_id), 0);
        check({tag, "_res_count"}, int'(bus.res_count), 0);
    endtask

    task automatic wait_ready(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("req_ready_%0d", id), int'(bus.req_ready[id]), 1);
    endtask

    task automatic send_packet(input int id, input int len, input int base, input int step);
        for (int b = 0; b < len; b++) begin
            bus.req_data[id*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(base + b * step);
            bus.req_last[id]  = (b == len - 1);
            bus.req_valid[id] = 1'b1;
            wait_ready(id);
            @(posedge clk);
            #1;
        end
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    // Waits for res_valid and, with res_ready high, lets it be accepted.
    task automatic get_result(output int d, output int i, output int c, output int wait_n);
        wait_n = 0;
        @(negedge clk);
        while (!bus.res_valid && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("res_valid_rise", int'(bus.res_valid), 1);
        d = int'(bus.res_data);
        i = int'(bus.res_id);
        c = int'(bus.res_count);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, i, c, w;
        int c0, e0, r0;
        int exp_ids [5];
        int exp_dat [5];

        vecs[0] = '{id: 0, len: 3,   base: 10,  step: 10, exp_sum: 60,    exp_cnt: 3};
        vecs[1] = '{id: 3, len: 1,   base: 200, step: 0,  exp_sum: 200,   exp_cnt: 1};
        vecs[2] = '{id: 1, len: 4,   base: 250, step: 1,  exp_sum: 1006,  exp_cnt: 4};
        vecs[3] = '{id: 2, len: 300, base: 255, step: 0,  exp_sum: 10964, exp_cnt: 44};
        vecs[4] = '{id: 2, len: 2,   base: 0,   step: 0,  exp_sum: 0,     exp_cnt: 2};
        exp_ids = '{0, 1, 2, 3, 0};
        exp_dat = '{1, 2, 3, 4, 1};

        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = 32'hA5A5_A5A5;
        bus.res_ready = 1'b1;

        // Reset state, with live data on the requester bus.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        bus.req_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single-requester packets.
        foreach (vecs[k]) begin
            c0 = clr_seen;
            e0 = en_seen;
            r0 = rv_seen;
            send_packet(vecs[k].id, vecs[k].len, vecs[k].base, vecs[k].step);
            get_result(d, i, c, w);
            check($sformatf("v%0d_sum", k), d, vecs[k].exp_sum);
            check($sformatf("v%0d_id", k), i, vecs[k].id);
            check($sformatf("v%0d_count", k), c, vecs[k].exp_cnt);
            check($sformatf("v%0d_latency", k), w, 1);
            check($sformatf("v%0d_en_cycles", k), en_seen - e0, vecs[k].len);
            check($sformatf("v%0d_clr_pulses", k), clr_seen - c0, 1);
            check($sformatf("v%0d_res_cycles", k), rv_seen - r0, 1);
        end

        // Round robin with all four requesters continuously valid.
        pulse_reset();
        bus.req_data  = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.req_last  = 4'hF;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            get_result(d, i, c, w);
            check($sformatf("rr%0d_id", k), i, exp_ids[k]);
            check($sformatf("rr%0d_data", k), d, exp_dat[k]);
        end
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Move the pointer to 1 so requester 2 wins against requester 1.
        send_packet(1, 1, 9, 0);
        get_result(d, i, c, w);
        check("pre_gap_sum", d, 9);

        bus.req_data[1*IN_WIDTH +: IN_WIDTH] = 8'd40;
        bus.req_last[1]  = 1'b1;
        bus.req_data[2*IN_WIDTH +: IN_WIDTH] = 8'd5;
        bus.req_last[2]  = 1'b0;
        bus.req_valid    = 4'b0110;
        wait_ready(2);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("gap%0d_ready1", k), int'(bus.req_ready[1]), 0);
            check($sformatf("gap%0d_ready2", k), int'(bus.req_ready[2]), 1);
            check($sformatf("gap%0d_acc_en", k), int'(acc_en), 0);
            @(posedge clk);
            #1;
        end
        bus.req_data[2*IN_WIDTH +: IN_WIDTH] = 8'd7;
        bus.req_last[2]  = 1'b1;
        bus.req_valid[2] = 1'b1;
        wait_ready(2);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        bus.req_last[2]  = 1'b0;
        get_result(d, i, c, w);
        check("gap_sum", d, 12);
        check("gap_id", i, 2);
        check("gap_count", c, 2);
        wait_ready(1);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        bus.req_last[1]  = 1'b0;
        get_result(d, i, c, w);
        check("next_id", i, 1);
        check("next_sum", d, 40);

        // Result backpressure.
        bus.res_ready = 1'b0;
        send_packet(3, 2, 17, 16);
        w = 0;
        @(negedge clk);
        while (!bus.res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_rise", int'(bus.res_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), int'(bus.res_valid), 1);
            check($sformatf("bp%0d_data", k), int'(bus.res_data), 50);
            check($sformatf("bp%0d_id", k), int'(bus.res_id), 3);
            check($sformatf("bp%0d_count", k), int'(bus.res_count), 2);
            check($sformatf("bp%0d_ready", k), int'(bus.req_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_valid", int'(bus.res_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_after_valid", int'(bus.res_valid), 0);
        check("bp_after_clr", int'(acc_clr), 0);

        // Reset in the middle of a packet from requester 0.
        @(posedge clk);
        #1;
        bus.req_data[0*IN_WIDTH +: IN_WIDTH] = 8'd100;
        bus.req_last[0]  = 1'b0;
        bus.req_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_all_zero($sformatf("midrst%0d", k));
        end
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        send_packet(0, 2, 3, 1);
        get_result(d, i, c, w);
        check("after_rst_sum", d, 7);
        check("after_rst_id", i, 0);
        check("after_rst_count", c, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
